// File: rtl/pll_phase_stepper_pkg.sv
// Shared definitions for the PLL phase stepper: FSM encoding, reset counter
// select and parameter defaults.
package pll_phase_stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_STEP      = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam logic [2:0] INIT_COUNTER         = 3'b110;
    localparam int         DEF_STEP_HIGH_CYCLES = 2;
    localparam int         DEF_TIMEOUT_CYCLES   = 255;

    // Compare in 9 bits so that a count of 255 never wraps into a false match.
    function automatic logic is_last_step(input logic [7:0] steps_done,
                                          input logic [7:0] periods);
        return ({1'b0, steps_done} + 9'd1) == {1'b0, periods};
    endfunction

endpackage

// File: rtl/phasedone_sync.sv
// Two-flop synchronizer for a PLL phasedone line; idles high like phasedone.
module phasedone_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_phase_stepper.sv
// Issues a burst of phasestep pulses to one of two PLLs, handshaking each step
// on the PLL's phasedone, with per-wait timeout abort. All logic on negedge.
module pll_phase_stepper
    import pll_phase_stepper_pkg::*;
#(
    parameter int STEP_HIGH_CYCLES = DEF_STEP_HIGH_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_shift_ready,
    input  logic [7:0] i_periods_to_process,
    input  logic [2:0] i_phasecounterselect_1,
    input  logic [2:0] i_phasecounterselect_2,
    input  logic       i_pll_to_update,
    input  logic       i_phaseupdown,
    input  logic       i_phasedone_1,
    input  logic       i_phasedone_2,
    output logic       o_phasestep_1,
    output logic       o_phasestep_2,
    output logic [2:0] o_phasecounterselect_1,
    output logic [2:0] o_phasecounterselect_2,
    output logic       o_phaseupdown,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_steps_done
);

    localparam logic [3:0]  STEP_LAST = 4'(STEP_HIGH_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_shift_prev;
    logic        r_armed;
    logic        w_start;

    logic        r_pll_sel;
    logic [7:0]  r_periods;
    logic [3:0]  r_step_cnt;
    logic [15:0] r_tmo_cnt;

    logic [1:0]  w_pd_async;
    logic [1:0]  w_pd_sync;
    logic        w_phasedone;

    logic        w_timeout;
    logic        w_sel_eff;
    logic        w_busy_next;
    logic        w_done_next;
    logic        w_step_1_next;
    logic        w_step_2_next;

    logic        r_phasestep_1;
    logic        r_phasestep_2;
    logic [2:0]  r_sel_1;
    logic [2:0]  r_sel_2;
    logic        r_updown;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [7:0]  r_steps_done;

    assign w_pd_async = {i_phasedone_2, i_phasedone_1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pd_sync
            phasedone_sync u_sync (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_async (w_pd_async[gi]),
                .o_sync  (w_pd_sync[gi])
            );
        end
    endgenerate

    assign w_phasedone = r_pll_sel ? w_pd_sync[1] : w_pd_sync[0];

    // r_armed blocks a strobe that is already high when reset releases.
    assign w_start = i_shift_ready & ~r_shift_prev & r_armed;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift_prev <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_shift_prev <= i_shift_ready;
            r_armed      <= 1'b1;
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_next = (i_periods_to_process == 8'd0) ? ST_FINISH : ST_STEP;
            end
            ST_STEP: begin
                if (r_step_cnt == STEP_LAST) begin
                    w_state_next = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!w_phasedone) begin
                    w_state_next = ST_WAIT_HIGH;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_phasedone) begin
                    w_state_next = ST_NEXT;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_NEXT: begin
                w_state_next = is_last_step(r_steps_done, r_periods) ? ST_FINISH : ST_STEP;
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state; in LATCH the PLL select is
    // still being captured, so the live input decides which phasestep fires.
    always_comb begin
        w_sel_eff     = (r_state == ST_LATCH) ? i_pll_to_update : r_pll_sel;
        w_busy_next   = (w_state_next != ST_IDLE);
        w_done_next   = (w_state_next == ST_FINISH);
        w_step_1_next = (w_state_next == ST_STEP) && !w_sel_eff;
        w_step_2_next = (w_state_next == ST_STEP) &&  w_sel_eff;
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phasestep_1 <= 1'b0;
            r_phasestep_2 <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_steps_done  <= 8'd0;
            r_sel_1       <= INIT_COUNTER;
            r_sel_2       <= INIT_COUNTER;
            r_updown      <= 1'b0;
            r_pll_sel     <= 1'b0;
            r_periods     <= 8'd0;
            r_step_cnt    <= 4'd0;
            r_tmo_cnt     <= 16'd0;
        end else begin
            r_phasestep_1 <= w_step_1_next;
            r_phasestep_2 <= w_step_2_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;

            if (r_state == ST_LATCH) begin
                r_periods    <= i_periods_to_process;
                r_pll_sel    <= i_pll_to_update;
                r_sel_1      <= i_phasecounterselect_1;
                r_sel_2      <= i_phasecounterselect_2;
                r_updown     <= i_phaseupdown;
                r_steps_done <= 8'd0;
                r_error      <= 1'b0;
            end else if (r_state == ST_NEXT) begin
                r_steps_done <= r_steps_done + 8'd1;
            end

            if (w_timeout) begin
                r_error <= 1'b1;
            end

            if (r_state == ST_STEP && w_state_next == ST_STEP) begin
                r_step_cnt <= r_step_cnt + 4'd1;
            end else begin
                r_step_cnt <= 4'd0;
            end

            // Restarts on every state change, so each wait state gets a full budget.
            if (w_state_next != r_state) begin
                r_tmo_cnt <= 16'd0;
            end else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    assign o_phasestep_1          = r_phasestep_1;
    assign o_phasestep_2          = r_phasestep_2;
    assign o_phasecounterselect_1 = r_sel_1;
    assign o_phasecounterselect_2 = r_sel_2;
    assign o_phaseupdown          = r_updown;
    assign o_busy                 = r_busy;
    assign o_done                 = r_done;
    assign o_error                = r_error;
    assign o_steps_done           = r_steps_done;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper with a simple two-PLL phasedone model.
module tb_pll_phase_stepper;

    localparam int STEP_HI = 2;
    localparam int TMO     = 16;

    typedef struct packed {
        logic [7:0] steps;
        logic       err;
        logic [7:0] dones;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [2:0] sel1;
        logic [2:0] sel2;
        logic       up;
        logic [7:0] bad_w;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_shift_ready = 1'b1;
    logic [7:0] i_periods_to_process = 8'd0;
    logic [2:0] i_phasecounterselect_1 = 3'd0;
    logic [2:0] i_phasecounterselect_2 = 3'd0;
    logic       i_pll_to_update = 1'b0;
    logic       i_phaseupdown = 1'b0;
    logic       i_phasedone_1;
    logic       i_phasedone_2;
    logic       o_phasestep_1;
    logic       o_phasestep_2;
    logic [2:0] o_phasecounterselect_1;
    logic [2:0] o_phasecounterselect_2;
    logic       o_phaseupdown;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_steps_done;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    int   mon_p1 = 0, mon_p2 = 0, run1 = 0, run2 = 0;
    int   mon_bad = 0, mon_done = 0, mon_busy = 0;
    int   base_p1 = 0, base_p2 = 0, base_bad = 0, base_done = 0, base_busy = 0;

    bit   pll_respond = 1'b1;
    logic ps1_prev = 1'b0, ps2_prev = 1'b0;
    int   pd_t1 = 0, pd_t2 = 0;

    logic [19:0] rst_vec_exp = 20'b0_0_0_00000000_0_0_110_110_0;

    pll_phase_stepper #(
        .STEP_HIGH_CYCLES (STEP_HI),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_shift_ready          (i_shift_ready),
        .i_periods_to_process   (i_periods_to_process),
        .i_phasecounterselect_1 (i_phasecounterselect_1),
        .i_phasecounterselect_2 (i_phasecounterselect_2),
        .i_pll_to_update        (i_pll_to_update),
        .i_phaseupdown          (i_phaseupdown),
        .i_phasedone_1          (i_phasedone_1),
        .i_phasedone_2          (i_phasedone_2),
        .o_phasestep_1          (o_phasestep_1),
        .o_phasestep_2          (o_phasestep_2),
        .o_phasecounterselect_1 (o_phasecounterselect_1),
        .o_phasecounterselect_2 (o_phasecounterselect_2),
        .o_phaseupdown          (o_phaseupdown),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_error                (o_error),
        .o_steps_done           (o_steps_done)
    );

    always #5 clk = ~clk;

    // PLL model: phasedone goes low 3 cycles after a phasestep fall, for 4 cycles.
    always @(posedge clk) begin
        if (pd_t1 != 0) pd_t1 = (pd_t1 == 7) ? 0 : pd_t1 + 1;
        else if (ps1_prev && !o_phasestep_1 && pll_respond) pd_t1 = 1;
        if (pd_t2 != 0) pd_t2 = (pd_t2 == 7) ? 0 : pd_t2 + 1;
        else if (ps2_prev && !o_phasestep_2 && pll_respond) pd_t2 = 1;
        ps1_prev = o_phasestep_1;
        ps2_prev = o_phasestep_2;
    end
    assign i_phasedone_1 = !(pd_t1 >= 4);
    assign i_phasedone_2 = !(pd_t2 >= 4);

    // Activity monitor: pulse counts, pulse widths, done and busy samples.
    always @(posedge clk) begin
        if (o_done) mon_done++;
        if (o_busy) mon_busy++;
        if (o_phasestep_1) run1++;
        else if (run1 != 0) begin
            mon_p1++;
            if (run1 != STEP_HI) mon_bad++;
            run1 = 0;
        end
        if (o_phasestep_2) run2++;
        else if (run2 != 0) begin
            mon_p2++;
            if (run2 != STEP_HI) mon_bad++;
            run2 = 0;
        end
    end

    function automatic res_t mk_exp(input int steps, input logic err, input int dones,
                                    input int p1, input int p2, input logic [2:0] s1,
                                    input logic [2:0] s2, input logic up);
        res_t r;
        r.steps = 8'(steps); r.err = err; r.dones = 8'(dones);
        r.p1 = 8'(p1); r.p2 = 8'(p2); r.sel1 = s1; r.sel2 = s2; r.up = up; r.bad_w = 8'd0;
        return r;
    endfunction

    function automatic res_t snapshot();
        res_t r;
        r.steps = o_steps_done; r.err = o_error; r.dones = 8'(mon_done - base_done);
        r.p1 = 8'(mon_p1 - base_p1); r.p2 = 8'(mon_p2 - base_p2);
        r.sel1 = o_phasecounterselect_1; r.sel2 = o_phasecounterselect_2;
        r.up = o_phaseupdown; r.bad_w = 8'(mon_bad - base_bad);
        return r;
    endfunction

    task automatic take_base();
        base_p1 = mon_p1; base_p2 = mon_p2; base_bad = mon_bad;
        base_done = mon_done; base_busy = mon_busy;
    endtask

    task automatic issue(input logic [7:0] per, input logic pll, input logic [2:0] s1,
                         input logic [2:0] s2, input logic up, input bit push, input res_t e);
        @(posedge clk);
        take_base();
        i_periods_to_process = per; i_pll_to_update = pll;
        i_phasecounterselect_1 = s1; i_phasecounterselect_2 = s2; i_phaseupdown = up;
        i_shift_ready = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        i_shift_ready = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (n = 0; n < budget; n++) begin
            @(posedge clk);
            if (o_busy) seen = 1'b1;
            else if (seen) break;
        end
        #1;
        checks++;
        if (n == budget) begin
            errors++;
            $display("FAIL wait_done: busy=%0b after %0d cycles, required 0", o_busy, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_error, o_steps_done, o_phasestep_1, o_phasestep_2,
             o_phasecounterselect_1, o_phasecounterselect_2, o_phaseupdown} !== rst_vec_exp) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", {o_busy, o_done, o_error,
                     o_steps_done, o_phasestep_1, o_phasestep_2, o_phasecounterselect_1,
                     o_phasecounterselect_2, o_phaseupdown}, rst_vec_exp);
        end
        @(posedge clk);
        rst_n = 1'b1;
        take_base();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ((mon_busy - base_busy) != 0 || (mon_p1 - base_p1) != 0 || (mon_p2 - base_p2) != 0) begin
            errors++;
            $display("FAIL strobe_high_at_release: busy_cycles=%0d pulses=%0d required 0 0",
                     mon_busy - base_busy, (mon_p1 - base_p1) + (mon_p2 - base_p2));
        end
        $display("txn reset: strobe held high across release, busy_cycles=%0d", mon_busy - base_busy);
        i_shift_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_pll1_up();
        res_t e, o;
        issue(8'd3, 1'b0, 3'b010, 3'b011, 1'b1, 1'b1, mk_exp(3, 0, 1, 3, 0, 3'b010, 3'b011, 1'b1));
        wait_done(400);
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pll1_up: got %h required %h", o, e);
        end
        $display("txn pll1_up: steps=%0d p1=%0d p2=%0d dones=%0d", o.steps, o.p1, o.p2, o.dones);
    endtask

    task automatic test_pll2_down();
        res_t e, o;
        issue(8'd1, 1'b1, 3'b000, 3'b101, 1'b0, 1'b1, mk_exp(1, 0, 1, 0, 1, 3'b000, 3'b101, 1'b0));
        wait_done(400);
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pll2_down: got %h required %h", o, e);
        end
        $display("txn pll2_down: sel2=%b up=%0b p2=%0d", o.sel2, o.up, o.p2);
    endtask

    task automatic test_zero_periods();
        res_t e, o;
        issue(8'd0, 1'b0, 3'b111, 3'b001, 1'b1, 1'b1, mk_exp(0, 0, 1, 0, 0, 3'b111, 3'b001, 1'b1));
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_cycle1: done=%b busy=%b required 0 1", o_done, o_busy);
        end
        @(posedge clk);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_cycle2: done=%b required 1", o_done);
        end
        @(posedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_cycle3: done=%b busy=%b required 0 0", o_done, o_busy);
        end
        #1;
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL zero_periods: got %h required %h", o, e);
        end
        $display("txn zero_periods: steps=%0d dones=%0d pulses=%0d", o.steps, o.dones, o.p1 + o.p2);
    endtask

    task automatic test_timeout();
        res_t e, o;
        pll_respond = 1'b0;
        issue(8'd3, 1'b0, 3'b011, 3'b001, 1'b1, 1'b1, mk_exp(0, 1, 0, 1, 0, 3'b011, 3'b001, 1'b1));
        wait_done(200);
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL timeout: got %h required %h", o, e);
        end
        $display("txn timeout: err=%0b busy=%0b dones=%0d p1=%0d", o.err, o_busy, o.dones, o.p1);
        pll_respond = 1'b1;
        issue(8'd1, 1'b1, 3'b100, 3'b010, 1'b0, 1'b1, mk_exp(1, 0, 1, 0, 1, 3'b100, 3'b010, 1'b0));
        @(posedge clk);
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: error=%b busy=%b required 0 1", o_error, o_busy);
        end
        wait_done(400);
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL after_timeout: got %h required %h", o, e);
        end
        $display("txn after_timeout: err=%0b steps=%0d p2=%0d", o.err, o.steps, o.p2);
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int   n;
        issue(8'd5, 1'b0, 3'b001, 3'b111, 1'b0, 1'b1, mk_exp(5, 0, 1, 5, 0, 3'b001, 3'b111, 1'b0));
        for (n = 0; n < 100 && (mon_p1 - base_p1) < 1; n++) @(posedge clk);
        @(posedge clk);
        i_periods_to_process = 8'd2; i_pll_to_update = 1'b1;
        i_phasecounterselect_1 = 3'b100; i_phasecounterselect_2 = 3'b010; i_phaseupdown = 1'b1;
        i_shift_ready = 1'b1;
        @(posedge clk);
        i_shift_ready = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (o_phasecounterselect_1 !== 3'b001 || o_phaseupdown !== 1'b0) begin
            errors++;
            $display("FAIL midcmd_inputs: sel1=%b up=%b required 001 0",
                     o_phasecounterselect_1, o_phaseupdown);
        end
        wait_done(400);
        e = exp_q.pop_front(); o = snapshot();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL back_to_back: got %h required %h", o, e);
        end
        $display("txn back_to_back: steps=%0d p1=%0d p2=%0d dones=%0d", o.steps, o.p1, o.p2, o.dones);
    endtask

    task automatic test_reset_mid();
        int n;
        res_t unused;
        unused = '0;
        issue(8'd4, 1'b0, 3'b010, 3'b011, 1'b1, 1'b0, unused);
        for (n = 0; n < 200 && (mon_p1 - base_p1) < 2; n++) @(posedge clk);
        for (n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (!i_phasedone_1) break;
        end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL reach_wait_high: phasedone_1=%b after 50 cycles, required 0", i_phasedone_1);
        end
        repeat (2) @(posedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_error, o_steps_done, o_phasestep_1, o_phasestep_2,
             o_phasecounterselect_1, o_phasecounterselect_2, o_phaseupdown} !== rst_vec_exp) begin
            errors++;
            $display("FAIL reset_mid_values: got %b required %b", {o_busy, o_done, o_error,
                     o_steps_done, o_phasestep_1, o_phasestep_2, o_phasecounterselect_1,
                     o_phasecounterselect_2, o_phaseupdown}, rst_vec_exp);
        end
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        take_base();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ((mon_busy - base_busy) != 0 || (mon_done - base_done) != 0 ||
            (mon_p1 - base_p1) != 0 || (mon_p2 - base_p2) != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: busy=%0d done=%0d pulses=%0d required 0 0 0",
                     mon_busy - base_busy, mon_done - base_done,
                     (mon_p1 - base_p1) + (mon_p2 - base_p2));
        end
        $display("txn reset_mid: outputs at reset values, quiet after release");
    endtask

    initial begin
        test_reset();
        test_pll1_up();
        test_pll2_down();
        test_zero_periods();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 Parameter STEP_HIGH_CYCLES, default 2, i_clk cycles o_phasestep_x is held high per step (legal 2..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, max i_clk cycles allowed in any wait state before abort (legal 16..65535).
REQ-003 i_clk  input  1  sole clock; all logic on negedge i_clk.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_shift_ready  input  1  command strobe from the UART mapper; a rising edge starts a command.
REQ-006 i_periods_to_process  input  8  number of phase steps to perform.
REQ-007 i_phasecounterselect_1 / i_phasecounterselect_2  input  3 each  counter select for PLL 1 / PLL 2.
REQ-008 i_pll_to_update  input  1  0 = PLL 1, 1 = PLL 2.
REQ-009 i_phaseupdown  input  1  step direction, 1 = up.
REQ-010 i_phasedone_1 / i_phasedone_2  input  1 each  PLL phasedone, asynchronous; low while a step is in progress.
REQ-011 o_phasestep_1 / o_phasestep_2  output  1 each  phasestep to PLL 1 / PLL 2.
REQ-012 o_phasecounterselect_1 / o_phasecounterselect_2  output  3 each  registered counter select to each PLL.
REQ-013 o_phaseupdown  output  1  registered direction to both PLLs.
REQ-014 o_busy  output  1  high from command accept until return to IDLE.
REQ-015 o_done  output  1  one-cycle pulse on successful completion.
REQ-016 o_error  output  1  sticky timeout flag; cleared by the next accepted command.
REQ-017 o_steps_done  output  8  steps completed in the current/last command.

Function
REQ-018 i_phasedone_1/2 SHALL pass through a 2-flop synchronizer; only the synchronized value of the selected PLL is used.
REQ-019 FSM states: IDLE, LATCH, STEP, WAIT_LOW, WAIT_HIGH, NEXT, FINISH.
REQ-020 IDLE: rising edge of i_shift_ready (registered previous value, 0 -> 1) -> LATCH; edges while not IDLE SHALL be ignored.
REQ-021 LATCH (1 cycle): capture periods, pll select, both counter selects, direction into internal/output registers; clear o_steps_done and o_error; o_busy=1; periods==0 -> FINISH, else STEP.
REQ-022 STEP: drive phasestep of the selected PLL only, high for exactly STEP_HIGH_CYCLES cycles, then low -> WAIT_LOW.
REQ-023 WAIT_LOW: synchronized phasedone low -> WAIT_HIGH; WAIT_HIGH: phasedone high -> NEXT.
REQ-024 NEXT (1 cycle): o_steps_done += 1; if o_steps_done+1 == latched periods -> FINISH, else STEP.
REQ-025 FINISH (1 cycle): o_done=1, o_busy=0 next cycle, -> IDLE.
REQ-026 Timeout counter (16 bit) SHALL reset on entry to WAIT_LOW and WAIT_HIGH; on reaching TIMEOUT_CYCLES: o_error=1, phasestep low, o_done NOT pulsed, -> IDLE.
REQ-027 Counter selects and o_phaseupdown SHALL be stable from LATCH until the next LATCH; never change while phasestep is high.
REQ-028 Inputs changing mid-command SHALL have no effect until the next accepted command.
REQ-029 o_steps_done SHALL NOT wrap; max 255 equals max periods.

Reset
REQ-030 On i_rst_n low, immediately: state IDLE, o_phasestep_1/2=0, o_phasecounterselect_1/2=3'b110, o_phaseupdown=0, o_busy=0, o_done=0, o_error=0, o_steps_done=0, synchronizers=1, previous-strobe register=0.
REQ-031 Reset mid-command SHALL abort with phasestep low within the reset assertion, no o_done.
REQ-032 An i_shift_ready already high at reset release SHALL NOT start a command.

Structure
REQ-033 Shared package: state encoding, INIT_COUNTER 3'b110, STEP_HIGH_CYCLES/TIMEOUT_CYCLES defaults.
REQ-034 One sub-module: phasedone_sync (2-flop synchronizer, instantiated twice).

Verification
REQ-035 PLL 1 model (phasedone low 3 cycles after phasestep fall, for 4 cycles), periods=3, up -> 3 phasestep_1 pulses of 2 cycles, phasestep_2 idle, o_steps_done=3, one o_done.
REQ-036 PLL 2, select 3'b101, down, periods=1 -> o_phasecounterselect_2=3'b101, o_phaseupdown=0, 1 pulse on phasestep_2.
REQ-037 periods=0 -> no phasestep, o_done pulse 2 cycles after strobe edge, o_steps_done=0.
REQ-038 phasedone held high, TIMEOUT_CYCLES=16 -> o_error=1 after one step, o_busy=0, no o_done; next command clears o_error.
REQ-039 Second i_shift_ready edge during a periods=5 command -> ignored, exactly 5 steps.
REQ-040 Reset asserted during WAIT_HIGH of step 2 -> all outputs to REQ-030 values; after release no activity until a new strobe edge.
